// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 8-bit 5-stage core. It keeps a shadow copy of the
// register usage of the instructions in EX, MEM and WB. From that it drives the
// registered EX operand-forward selects and the stall, flush and freeze
// controls, all of which the datapath acts on in the same cycle.
module hazard_forward_ctrl #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            use1;
    logic            use2;
  } ex_sh_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } mem_sh_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
  } wb_sh_t;

  ex_sh_t           ex_q,  ex_d;
  mem_sh_t          mem_q, mem_d;
  wb_sh_t           wb_q,  wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic freeze, flush, stall, enter, hit1, hit2;

  // Youngest producer wins: a non-load in EX (about to sit in EX/MEM) beats
  // any writer in MEM (about to sit in MEM/WB). A load in EX never forwards
  // from EX/MEM; the stall logic keeps its consumer back instead.
  function automatic logic [1:0] fwd_sel(input logic en, input logic use_rs,
                                         input logic [RA_W-1:0] rs,
                                         input ex_sh_t ex, input mem_sh_t mem);
    fwd_sel = FWD_RF;
    if (en && use_rs) begin
      if (ex.valid && ex.reg_write && !ex.mem_read && ex.rd == rs)
        fwd_sel = FWD_EXMEM;
      else if (mem.valid && mem.reg_write && mem.rd == rs)
        fwd_sel = FWD_MEMWB;
    end
  endfunction

  // Hazard decode. Freeze beats flush, and flush beats a load-use stall,
  // because a squashed ID instruction has nothing to wait for.
  always_comb begin
    freeze = mem_q.valid & mem_q.mem_read & ~mem_ready_i;
    flush  = ~freeze & ex_q.valid & branch_taken_i;
    hit1   = id_use_rs1_i & (id_rs1_i == ex_q.rd);
    hit2   = id_use_rs2_i & (id_rs2_i == ex_q.rd);
    stall  = ~freeze & ~flush & id_valid_i & ex_q.valid & ex_q.mem_read &
             ex_q.reg_write & (hit1 | hit2);
    enter  = id_valid_i & ~stall & ~flush;
  end

  // Shadow pipeline and forward selects advance together unless frozen.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!freeze) begin
      wb_d    = '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
      mem_d   = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                  mem_read: ex_q.mem_read};
      ex_d    = '{valid: enter, rd: id_rd_i, reg_write: id_reg_write_i,
                  mem_read: id_mem_read_i, rs1: id_rs1_i, rs2: id_rs2_i,
                  use1: id_use_rs1_i, use2: id_use_rs2_i};
      fwd_a_d = fwd_sel(enter, id_use_rs1_i, id_rs1_i, ex_q, mem_q);
      fwd_b_d = fwd_sel(enter, id_use_rs2_i, id_rs2_i, ex_q, mem_q);
    end
  end

  // Saturating count of cycles lost to stall or freeze; flushes not counted.
  always_comb begin
    cnt_d = cnt_q;
    if ((stall || freeze) && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset drops every pending action at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // The WB shadow and the EX source fields are kept for debug visibility only.
  // The register file resolves WB-versus-ID by write-through, so no output
  // reads them.
  logic unused_shadow;
  assign unused_shadow = ^{ex_q, wb_q};

  assign forward_a_o   = fwd_a_q;
  assign forward_b_o   = fwd_b_q;
  assign stall_o       = stall;
  assign flush_o       = flush;
  assign freeze_o      = freeze;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl. It applies a directed cycle table, a freeze
// saturation and async-reset sequence, and then a randomized run that is
// compared against an instruction-level model.
module tb_hazard_forward_ctrl;
  localparam int RA_W  = 3;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic branch_taken, mem_ready;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0] forward_a, forward_b;
  logic stall, flush, freeze;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
    .forward_a_o(forward_a), .forward_b_o(forward_b),
    .stall_o(stall), .flush_o(flush), .freeze_o(freeze),
    .stall_count_o(stall_count)
  );

  typedef struct {
    logic v; logic [2:0] rs1, rs2; logic u1, u2; logic [2:0] rd;
    logic rw, mr, bt, rdy;
    logic [1:0] fa, fb; logic st, fl, fz; int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic u1, input logic u2, input logic [2:0] rd,
                       input logic rw, input logic mr, input logic bt, input logic rdy);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; branch_taken = bt; mem_ready = rdy;
  endtask

  task automatic add(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic u1, input logic u2, input logic [2:0] rd,
                     input logic rw, input logic mr, input logic bt, input logic rdy,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic fl, input logic fz, input int cnt);
    vec_t t;
    t = '{v, rs1, rs2, u1, u2, rd, rw, mr, bt, rdy, fa, fb, st, fl, fz, cnt};
    tbl.push_back(t);
  endtask

  // One plain cycle with no checks: drive, let it settle, take the edge.
  task automatic cyc(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic u1, input logic u2, input logic [2:0] rd,
                     input logic rw, input logic mr, input logic bt, input logic rdy);
    drive(v, rs1, rs2, u1, u2, rd, rw, mr, bt, rdy);
    #2;
    @(posedge clk); #1;
  endtask

  // Instruction-level model: in-flight instructions by age, 0=EX 1=MEM 2=WB.
  typedef struct { logic v; logic [2:0] rd; logic rw, mr; } mi_t;
  mi_t mp[3];
  logic [1:0] m_fa, m_fb;
  int m_cnt;

  task automatic m_reset();
    for (int k = 0; k < 3; k++) mp[k] = '{1'b0, 3'd0, 1'b0, 1'b0};
    m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
  endtask

  // Operand source for a reader: the youngest older writer, with loads in EX
  // unable to supply a value yet.
  function automatic logic [1:0] m_src(input logic en, input logic u, input logic [2:0] rs);
    if (!en || !u) return 2'b00;
    if (mp[0].v && mp[0].rw && !mp[0].mr && mp[0].rd == rs) return 2'b01;
    if (mp[1].v && mp[1].rw && mp[1].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    logic m_fz, m_fl, m_st, en;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fa", 32'(forward_a), 0);
    chk("reset_fb", 32'(forward_b), 0);
    chk("reset_cnt", 32'(stall_count), 0);
    chk("reset_ctl", 32'({stall, flush, freeze}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //   v rs1 rs2 u1 u2 rd rw mr bt rdy | fa fb st fl fz cnt
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0); // ADD r1
    add(1, 1, 3, 1, 1, 2, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0); // SUB r2,r1,r3
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0); // fa=01 ; write r4
    add(1, 0, 0, 0, 0, 6, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0); // write r6
    add(1, 0, 4, 0, 1, 7, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0); // read r4 (in MEM)
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 1,   0, 2, 0, 0, 0, 0); // fb=10 ; write r4
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0); // write r4 again
    add(1, 0, 4, 0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0); // read r4, both writers
    add(1, 0, 0, 0, 0, 5, 1, 1, 0, 1,   0, 1, 0, 0, 0, 0); // fb=01 ; LD r5
    add(1, 5, 0, 1, 0, 2, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0); // load-use stall
    add(1, 5, 0, 1, 0, 2, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1); // re-presented
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 1); // fa=10
    add(1, 0, 0, 0, 0, 6, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1); // ADD r6
    add(1, 6, 0, 1, 0, 3, 1, 1, 0, 1,   0, 0, 0, 0, 0, 1); // LD r3 reads r6
    add(1, 0, 6, 0, 1, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1); // reader r6
    add(1, 3, 0, 1, 0, 1, 1, 0, 0, 0,   0, 2, 0, 0, 1, 1); // freeze 1
    add(1, 3, 0, 1, 0, 1, 1, 0, 0, 0,   0, 2, 0, 0, 1, 2); // freeze 2
    add(1, 3, 0, 1, 0, 1, 1, 0, 0, 0,   0, 2, 0, 0, 1, 3); // freeze 3
    add(1, 3, 0, 1, 0, 1, 1, 0, 0, 1,   0, 2, 0, 0, 0, 4); // resumes
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 4); // fa=10 from load
    add(1, 0, 0, 0, 0, 5, 1, 1, 0, 1,   0, 0, 0, 0, 0, 4); // LD r5
    add(1, 5, 0, 1, 0, 2, 1, 0, 1, 1,   0, 0, 0, 1, 0, 4); // branch beats load-use
    add(1, 5, 0, 1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 4); // EX now empty: no flush
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 4); // fa=10

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].bt, tbl[i].rdy);
      #2;
      chk($sformatf("v%0d_fa", i), 32'(forward_a), 32'(tbl[i].fa));
      chk($sformatf("v%0d_fb", i), 32'(forward_b), 32'(tbl[i].fb));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].fl));
      chk($sformatf("v%0d_freeze", i), 32'(freeze), 32'(tbl[i].fz));
      chk($sformatf("v%0d_cnt", i), 32'(stall_count), 32'(tbl[i].cnt));
      @(posedge clk); #1;
    end

    // Long freeze: the counter saturates and the select is held throughout.
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0, 1);   // ADD r6
    cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 1);   // LD r3
    cyc(1, 6, 0, 1, 0, 0, 0, 0, 0, 1);   // reader r6 enters with fa=10
    repeat (40) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_freeze", 32'(freeze), 1);
    chk("sat_fa_held", 32'(forward_a), 2);
    chk("sat_cnt", 32'(stall_count), CMAX);

    // Reset mid-freeze clears everything before the next edge.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_fa", 32'(forward_a), 0);
    chk("arst_cnt", 32'(stall_count), 0);
    chk("arst_ctl", 32'({stall, flush, freeze}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;

    // Randomized run against the model; small register space for many hazards.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 9) < 8, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7);
      #2;
      m_fz = mp[1].v && mp[1].mr && !mem_ready;
      m_fl = !m_fz && mp[0].v && branch_taken;
      m_st = !m_fz && !m_fl && id_valid && mp[0].v && mp[0].mr && mp[0].rw &&
             ((id_use_rs1 && id_rs1 == mp[0].rd) || (id_use_rs2 && id_rs2 == mp[0].rd));
      chk("rnd_fa", 32'(forward_a), 32'(m_fa));
      chk("rnd_fb", 32'(forward_b), 32'(m_fb));
      chk("rnd_stall", 32'(stall), 32'(m_st));
      chk("rnd_flush", 32'(flush), 32'(m_fl));
      chk("rnd_freeze", 32'(freeze), 32'(m_fz));
      chk("rnd_cnt", 32'(stall_count), 32'(m_cnt));
      if (!m_fz) begin
        en = id_valid && !m_st && !m_fl;
        m_fa = m_src(en, id_use_rs1, id_rs1);
        m_fb = m_src(en, id_use_rs2, id_rs2);
        mp[2] = mp[1];
        mp[1] = mp[0];
        mp[0] = '{en, id_rd, id_reg_write, id_mem_read};
      end
      if ((m_st || m_fz) && m_cnt < CMAX) m_cnt++;
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
